// File: rtl/sprite_renderer.sv
// Sprite/separator renderer: snapshots sprite state each frame, hit-tests the VGA
// pixel stream in two stages and reports ball-vs-paddle overlap per frame.
package sprite_pkg;
   localparam int X_POS_W              = 10;
   localparam int Y_POS_W              = 10;
   localparam int H_RES                = 640;
   localparam int N_SPRITES            = 3;
   localparam int SEPARATOR_WIDTH      = 6;
   localparam int SEPARATOR_DOT_HEIGHT = 18;

   typedef struct packed {
      logic [X_POS_W-1:0] x_pos;
      logic [Y_POS_W-1:0] y_pos;
      logic [X_POS_W-1:0] right;
      logic [Y_POS_W-1:0] bottom;
   } sprite_t;
endpackage

module sprite_hit
   import sprite_pkg::*;
(
   input  sprite_t            spr,
   input  logic [X_POS_W-1:0] x,
   input  logic [Y_POS_W-1:0] y,
   output logic               hit
);
   // Half-open box; a degenerate box (right <= x_pos or bottom <= y_pos) never matches.
   assign hit = (x >= spr.x_pos) && (x < spr.right) && (y >= spr.y_pos) && (y < spr.bottom);
endmodule

module sprite_renderer
   import sprite_pkg::*;
#(
   parameter int                 N_SPR     = N_SPRITES,
   parameter int                 COLOR_W   = 12,
   parameter logic [COLOR_W-1:0] FG_COLOR  = 12'hFFF,
   parameter logic [COLOR_W-1:0] BG_COLOR  = 12'h000,
   parameter int                 SEP_WIDTH = SEPARATOR_WIDTH,
   parameter int                 SEP_DOT_H = SEPARATOR_DOT_HEIGHT
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  sprite_t [N_SPR-1:0]  sprites_i,
   input  logic                 frame_start_i,
   input  logic [X_POS_W-1:0]   x_i,
   input  logic [Y_POS_W-1:0]   y_i,
   input  logic                 visible_i,
   input  logic                 hsync_i,
   input  logic                 vsync_i,
   output logic [COLOR_W-1:0]   rgb_o,
   output logic                 hsync_o,
   output logic                 vsync_o,
   output logic [1:0]           collision_o,
   output logic                 collision_valid_o
);
   localparam int BALL  = 2;
   localparam int CNT_W = $clog2(SEP_DOT_H);
   localparam logic [X_POS_W-1:0] SEP_LO = X_POS_W'(H_RES/2 - SEP_WIDTH/2);
   localparam logic [X_POS_W-1:0] SEP_HI = X_POS_W'(H_RES/2 + SEP_WIDTH/2);

   sprite_t [N_SPR-1:0] shadow;
   logic    [N_SPR-1:0] hit0, hit1;
   logic                sep1, vis1, hs1, vs1;
   logic    [1:0]       acc, contrib;

   logic [Y_POS_W-1:0] prev_y;
   logic [CNT_W-1:0]   dot_cnt, dot_cnt_cur;
   logic               band_odd, band_odd_cur;

   for (genvar i = 0; i < N_SPR; i++) begin : g_hit
      sprite_hit u_hit (.spr(shadow[i]), .x(x_i), .y(y_i), .hit(hit0[i]));
   end

   // Row-band tracker: advances once per new row, restarts at y = 0.
   always_comb begin
      dot_cnt_cur  = dot_cnt;
      band_odd_cur = band_odd;
      if (y_i == '0) begin
         dot_cnt_cur  = '0;
         band_odd_cur = 1'b0;
      end else if (y_i != prev_y) begin
         if (dot_cnt == CNT_W'(SEP_DOT_H - 1)) begin
            dot_cnt_cur  = '0;
            band_odd_cur = ~band_odd;
         end else begin
            dot_cnt_cur = dot_cnt + 1'b1;
         end
      end
   end

   assign contrib = {vis1 & hit1[BALL] & hit1[1], vis1 & hit1[BALL] & hit1[0]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow            <= '0;
         prev_y            <= '0;
         dot_cnt           <= '0;
         band_odd          <= 1'b0;
         hit1              <= '0;
         sep1              <= 1'b0;
         vis1              <= 1'b0;
         hs1               <= 1'b0;
         vs1               <= 1'b0;
         rgb_o             <= BG_COLOR;
         hsync_o           <= 1'b0;
         vsync_o           <= 1'b0;
         acc               <= '0;
         collision_o       <= '0;
         collision_valid_o <= 1'b0;
      end else begin
         if (frame_start_i) shadow <= sprites_i;
         prev_y   <= y_i;
         dot_cnt  <= dot_cnt_cur;
         band_odd <= band_odd_cur;

         hit1 <= hit0;
         sep1 <= (x_i >= SEP_LO) && (x_i < SEP_HI) && !band_odd_cur;
         vis1 <= visible_i;
         hs1  <= hsync_i;
         vs1  <= vsync_i;

         rgb_o   <= (vis1 && ((|hit1) || sep1)) ? FG_COLOR : BG_COLOR;
         hsync_o <= hs1;
         vsync_o <= vs1;

         // Stage-1 contributions present on the boundary cycle close out the old frame.
         if (frame_start_i) begin
            collision_o       <= acc | contrib;
            collision_valid_o <= 1'b1;
            acc               <= '0;
         end else begin
            acc               <= acc | contrib;
            collision_valid_o <= 1'b0;
         end
      end
   end
endmodule
